// File: rtl/rv_pkg.sv
// Shared integer-pipeline constants and types for the register file slice.
// Pure declarations: no latency, no flow control.
package rv_pkg;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int IDXW  = 5;

    typedef logic [IDXW-1:0] reg_idx_t;
    typedef logic [XLEN-1:0] xlen_t;

    typedef enum logic {
        RF_CLEAR,
        RF_RUN
    } rf_state_t;

endpackage

// File: rtl/reg_file_wb_sink_if.sv
// Write-back write port plus two decode read ports of the register file.
// Master drives indices/write data; slave returns registered read data, ready and drop pulse.
interface reg_file_wb_sink_if;
    import rv_pkg::*;

    reg_idx_t i_rd_index;
    xlen_t    i_rd_data;
    logic     i_rd_we;
    reg_idx_t i_rs1_index;
    reg_idx_t i_rs2_index;
    xlen_t    o_rs1_value;
    xlen_t    o_rs2_value;
    logic     o_ready;
    logic     o_write_drop;

    modport master (
        output i_rd_index, i_rd_data, i_rd_we, i_rs1_index, i_rs2_index,
        input  o_rs1_value, o_rs2_value, o_ready, o_write_drop
    );

    modport slave (
        input  i_rd_index, i_rd_data, i_rd_we, i_rs1_index, i_rs2_index,
        output o_rs1_value, o_rs2_value, o_ready, o_write_drop
    );

endinterface

// File: rtl/reg_file_wb_sink_read_port.sv
// One registered read port: x0 zeroing, write-first bypass, 1-cycle latency.
// No backpressure; output is held at zero while the file is not running.
module rf_read_port
    import rv_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     i_run,
    input  reg_idx_t i_index,
    input  xlen_t    i_reg_value,
    input  logic     i_wr_acc,
    input  reg_idx_t i_wr_index,
    input  xlen_t    i_wr_data,
    output xlen_t    o_value
);

    // i_wr_acc already excludes x0, so a match here is always a real register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_run || i_index == '0) begin
            o_value <= '0;
        end else if (i_wr_acc && i_wr_index == i_index) begin
            o_value <= i_wr_data;
        end else begin
            o_value <= i_reg_value;
        end
    end

endmodule

// File: rtl/reg_file_wb_sink.sv
// 32 x XLEN register file terminating write-back; sweeps to zero after reset, then RUN.
// Reads 1-cycle registered with bypass; writes arriving before ready are dropped and flagged.
module reg_file_wb_sink
    import rv_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    reg_file_wb_sink_if.slave  wb
);

    localparam logic [IDXW:0] LAST_IDX = (IDXW+1)'(NREGS-1);

    rf_state_t       state_q, state_d;
    logic [IDXW:0]   cnt_q, cnt_d;
    logic            drop_q;
    logic            run;
    logic            wr_acc;
    xlen_t           rf [NREGS];

    assign run    = (state_q == RF_RUN);
    assign wr_acc = run && wb.i_rd_we && (wb.i_rd_index != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RF_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = RF_RUN;
                end
            end
            RF_RUN:  state_d = RF_RUN;
            default: state_d = RF_CLEAR;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= !run && wb.i_rd_we;
        end
    end

    // Storage has no reset of its own; the sweep zeroes one entry per cycle instead.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (!run) begin
                rf[cnt_q[IDXW-1:0]] <= '0;
            end else if (wr_acc) begin
                rf[wb.i_rd_index] <= wb.i_rd_data;
            end
        end
    end

    rf_read_port u_rs1 (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_run       (run),
        .i_index     (wb.i_rs1_index),
        .i_reg_value (rf[wb.i_rs1_index]),
        .i_wr_acc    (wr_acc),
        .i_wr_index  (wb.i_rd_index),
        .i_wr_data   (wb.i_rd_data),
        .o_value     (wb.o_rs1_value)
    );

    rf_read_port u_rs2 (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_run       (run),
        .i_index     (wb.i_rs2_index),
        .i_reg_value (rf[wb.i_rs2_index]),
        .i_wr_acc    (wr_acc),
        .i_wr_index  (wb.i_rd_index),
        .i_wr_data   (wb.i_rd_data),
        .o_value     (wb.o_rs2_value)
    );

    assign wb.o_ready      = run;
    assign wb.o_write_drop = drop_q;

endmodule

// File: tb/tb_reg_file_wb_sink.sv
// Self-checking bench for reg_file_wb_sink: directed table, corner sequences, random vs model.
module tb_reg_file_wb_sink;
    import rv_pkg::*;

    logic clk;
    logic rst_n;

    reg_file_wb_sink_if bus ();

    reg_file_wb_sink dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .wb      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    xlen_t m_regs [NREGS];
    int    m_since  = 0;

    typedef struct {
        logic     we;
        reg_idx_t rd;
        xlen_t    d;
        reg_idx_t r1;
        reg_idx_t r2;
        xlen_t    e1;
        xlen_t    e2;
        logic     ed;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic xlen_t model_read(input logic rst, input logic rdy, input logic acc,
                                         input reg_idx_t rd, input xlen_t d, input reg_idx_t r);
        if (!rst || !rdy || r == 0) return '0;
        if (acc && rd == r) return d;
        return m_regs[r];
    endfunction

    // One clock: drive at negedge, advance the model across the edge, compare just after it.
    task automatic step(input logic rst, input logic we, input reg_idx_t rd, input xlen_t d,
                        input reg_idx_t r1, input reg_idx_t r2);
        logic  rdy_pre, acc, ed, er;
        xlen_t e1, e2;
        @(negedge clk);
        rst_n           = rst;
        bus.i_rd_we     = we;
        bus.i_rd_index  = rd;
        bus.i_rd_data   = d;
        bus.i_rs1_index = r1;
        bus.i_rs2_index = r2;
        rdy_pre = (m_since >= NREGS);
        acc     = rst && rdy_pre && we && (rd != 0);
        e1      = model_read(rst, rdy_pre, acc, rd, d, r1);
        e2      = model_read(rst, rdy_pre, acc, rd, d, r2);
        ed      = rst && !rdy_pre && we;
        if (!rst) begin
            m_since = 0;
        end else if (m_since < NREGS) begin
            m_since++;
            if (m_since == NREGS) begin
                for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
            end
        end
        if (acc) m_regs[rd] = d;
        er = (m_since >= NREGS);
        @(posedge clk);
        #1;
        chk("ready", 64'(bus.o_ready), 64'(er));
        chk("rs1", bus.o_rs1_value, e1);
        chk("rs2", bus.o_rs2_value, e2);
        chk("drop", 64'(bus.o_write_drop), 64'(ed));
    endtask

    task automatic idle();
        step(1'b1, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            idle();
            n++;
            if (bus.o_ready) break;
        end
    endtask

    int n;

    initial begin
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        tbl[0] = '{1'b1, 5'd7, 64'hDEAD_BEEF_0000_0001, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0};
        tbl[1] = '{1'b0, 5'd0, 64'd0, 5'd7, 5'd5, 64'hDEAD_BEEF_0000_0001, 64'd0, 1'b0};
        tbl[2] = '{1'b1, 5'd3, 64'h55, 5'd3, 5'd3, 64'h55, 64'h55, 1'b0};
        tbl[3] = '{1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd7, 64'd0, 64'hDEAD_BEEF_0000_0001, 1'b0};
        tbl[4] = '{1'b0, 5'd0, 64'd0, 5'd0, 5'd3, 64'd0, 64'h55, 1'b0};
        tbl[5] = '{1'b1, 5'd7, 64'h1234, 5'd7, 5'd3, 64'h1234, 64'h55, 1'b0};
        tbl[6] = '{1'b0, 5'd0, 64'd0, 5'd7, 5'd7, 64'h1234, 64'h1234, 1'b0};

        rst_n = 1'b0;
        bus.i_rd_we = 1'b0; bus.i_rd_index = '0; bus.i_rd_data = '0;
        bus.i_rs1_index = '0; bus.i_rs2_index = '0;

        // Reset, then sweep length.
        step(1'b0, 1'b1, 5'd4, 64'h99, 5'd4, 5'd4);
        step(1'b0, 1'b0, '0, '0, 5'd1, 5'd2);
        chk("rst_ready", 64'(bus.o_ready), 64'd0);
        chk("rst_drop", 64'(bus.o_write_drop), 64'd0);
        wait_ready(n);
        chk("sweep_len", 64'(n), 64'd32);
        step(1'b1, 1'b0, '0, '0, 5'd5, 5'd5);
        chk("x5_after_clear", bus.o_rs1_value, 64'd0);

        for (int i = 0; i < 7; i++) begin
            step(1'b1, tbl[i].we, tbl[i].rd, tbl[i].d, tbl[i].r1, tbl[i].r2);
            chk($sformatf("tbl%0d_rs1", i), bus.o_rs1_value, tbl[i].e1);
            chk($sformatf("tbl%0d_rs2", i), bus.o_rs2_value, tbl[i].e2);
            chk($sformatf("tbl%0d_drop", i), 64'(bus.o_write_drop), 64'(tbl[i].ed));
        end

        // Write during CLEAR at sweep cycle 10 is dropped and flagged once.
        step(1'b0, 1'b0, '0, '0, '0, '0);
        for (int i = 0; i < 9; i++) idle();
        step(1'b1, 1'b1, 5'd9, 64'h12, 5'd9, 5'd9);
        chk("drop_pulse", 64'(bus.o_write_drop), 64'd1);
        idle();
        chk("drop_single", 64'(bus.o_write_drop), 64'd0);
        wait_ready(n);
        chk("sweep_rest", 64'(n), 64'd21);
        step(1'b1, 1'b0, '0, '0, 5'd9, 5'd0);
        chk("x9_dropped", bus.o_rs1_value, 64'd0);

        // Reset in RUN, then again mid-sweep: sweep restarts, x4 cleared.
        step(1'b1, 1'b1, 5'd4, 64'hAA, 5'd0, 5'd0);
        step(1'b1, 1'b0, '0, '0, 5'd4, 5'd0);
        chk("x4_written", bus.o_rs1_value, 64'hAA);
        step(1'b0, 1'b0, '0, '0, 5'd4, 5'd4);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, '0, '0, 5'd4, 5'd4);
        step(1'b0, 1'b0, '0, '0, 5'd4, 5'd4);
        wait_ready(n);
        chk("sweep_restart", 64'(n), 64'd32);
        step(1'b1, 1'b0, '0, '0, 5'd4, 5'd4);
        chk("x4_cleared", bus.o_rs2_value, 64'd0);

        // Random traffic with occasional resets, checked against the model every cycle.
        for (int i = 0; i < 600; i++) begin
            logic     rst, we;
            reg_idx_t rd, r1, r2;
            xlen_t    d;
            rst = ($urandom_range(0, 149) != 0);
            we  = $urandom_range(0, 1) != 0;
            rd  = reg_idx_t'($urandom_range(0, NREGS-1));
            d   = {$urandom, $urandom};
            r1  = ($urandom_range(0, 2) == 0) ? rd : reg_idx_t'($urandom_range(0, NREGS-1));
            r2  = ($urandom_range(0, 2) == 0) ? rd : reg_idx_t'($urandom_range(0, NREGS-1));
            step(rst, we, rd, d, r1, r2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
